// File: rtl/mfp_adc_max10_arbiter.sv
// mfp_adc_max10_arbiter: packet-atomic arbiter sharing one MAX10 ADC sequencer port between two requesters.
// Define MFP_ADC_ARB_FIXED_PRIO_EN to give R0 fixed priority instead of round-robin.
module mfp_adc_max10_arbiter #(
    parameter int OWNER_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        R0_C_Valid,
    input  logic [4:0]  R0_C_Channel,
    input  logic        R0_C_SOP,
    input  logic        R0_C_EOP,
    output logic        R0_C_Ready,
    input  logic        R1_C_Valid,
    input  logic [4:0]  R1_C_Channel,
    input  logic        R1_C_SOP,
    input  logic        R1_C_EOP,
    output logic        R1_C_Ready,
    output logic        ADC_C_Valid,
    output logic [4:0]  ADC_C_Channel,
    output logic        ADC_C_SOP,
    output logic        ADC_C_EOP,
    input  logic        ADC_C_Ready,
    input  logic        ADC_R_Valid,
    input  logic [4:0]  ADC_R_Channel,
    input  logic [11:0] ADC_R_Data,
    input  logic        ADC_R_SOP,
    input  logic        ADC_R_EOP,
    output logic        R0_R_Valid,
    output logic        R1_R_Valid,
    output logic [4:0]  R_Channel,
    output logic [11:0] R_Data,
    output logic        R_SOP,
    output logic        R_EOP,
    output logic        Orphan,
    input  logic        Orphan_clr
);
    localparam int AW = $clog2(OWNER_DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(OWNER_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]             r_state;
    logic [OWNER_DEPTH-1:0] r_fifo;
    logic [AW-1:0]          r_wp;
    logic [AW-1:0]          r_rp;
    logic [AW:0]            r_cnt;
    logic                   r_orphan;
    logic w_own0, w_own1, w_idle, w_full, w_empty;
    logic w_c0, w_c1, w_gnt0, w_gnt1, w_push, w_pop, w_head, w_done;

    assign w_own0  = r_state == S_OWN0;
    assign w_own1  = r_state == S_OWN1;
    assign w_idle  = ~w_own0 & ~w_own1;
    assign w_full  = r_cnt == C_FULL;
    assign w_empty = r_cnt == '0;
    assign w_c0    = R0_C_Valid & R0_C_SOP;
    assign w_c1    = R1_C_Valid & R1_C_SOP;

`ifdef MFP_ADC_ARB_FIXED_PRIO_EN
    assign w_gnt1 = w_c1 & ~w_c0;
`else
    logic r_last;
    // r_last = 1 means R1 was granted last, so R0 wins the next tie
    assign w_gnt1 = w_c1 & (~w_c0 | ~r_last);
    always_ff @(posedge CLK)
        if (!RESETn) r_last <= 1'b1;
        else if (w_done) r_last <= w_own1;
`endif
    assign w_gnt0 = w_c0 & ~w_gnt1;

    assign ADC_C_Valid   = ~w_full & (w_own0 ? R0_C_Valid : w_own1 & R1_C_Valid);
    assign ADC_C_Channel = w_own0 ? R0_C_Channel : w_own1 ? R1_C_Channel : 5'd0;
    assign ADC_C_SOP     = w_own0 ? R0_C_SOP : w_own1 & R1_C_SOP;
    assign ADC_C_EOP     = w_own0 ? R0_C_EOP : w_own1 & R1_C_EOP;
    // Non-SOP beats seen while idle are swallowed so a malformed stream cannot deadlock
    assign R0_C_Ready = w_own0 ? ADC_C_Ready & ~w_full : w_idle & R0_C_Valid & ~R0_C_SOP;
    assign R1_C_Ready = w_own1 ? ADC_C_Ready & ~w_full : w_idle & R1_C_Valid & ~R1_C_SOP;

    assign w_push = ADC_C_Valid & ADC_C_Ready;
    assign w_done = w_push & ADC_C_EOP;
    assign w_pop  = ADC_R_Valid & ~w_empty;
    assign w_head = r_fifo[r_rp];

    assign R0_R_Valid = w_pop & ~w_head;
    assign R1_R_Valid = w_pop & w_head;
    assign R_Channel  = ADC_R_Channel;
    assign R_Data     = ADC_R_Data;
    assign R_SOP      = ADC_R_SOP;
    assign R_EOP      = ADC_R_EOP;
    assign Orphan     = r_orphan;

    always_ff @(posedge CLK)
        if (w_push) r_fifo[r_wp] <= w_own1;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state  <= S_IDLE;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_idle) r_state <= w_gnt0 ? S_OWN0 : w_gnt1 ? S_OWN1 : S_IDLE;
            else if (w_done) r_state <= S_IDLE;
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt    <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_orphan <= (ADC_R_Valid & w_empty) | (r_orphan & ~Orphan_clr);
        end
    end
endmodule

// File: tb/tb_mfp_adc_max10_arbiter.sv
// tb_mfp_adc_max10_arbiter: directed self-checking bench for mfp_adc_max10_arbiter (OWNER_DEPTH = 4).
// Tie expectations follow MFP_ADC_ARB_FIXED_PRIO_EN when it is defined.
module tb_mfp_adc_max10_arbiter;
    logic        CLK = 1'b0;
    logic        RESETn;
    logic        R0_C_Valid, R0_C_SOP, R0_C_EOP, R0_C_Ready;
    logic [4:0]  R0_C_Channel;
    logic        R1_C_Valid, R1_C_SOP, R1_C_EOP, R1_C_Ready;
    logic [4:0]  R1_C_Channel;
    logic        ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Ready;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_R_Valid, ADC_R_SOP, ADC_R_EOP;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;
    logic        R0_R_Valid, R1_R_Valid, R_SOP, R_EOP;
    logic [4:0]  R_Channel;
    logic [11:0] R_Data;
    logic        Orphan, Orphan_clr;
    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mfp_adc_max10_arbiter #(.OWNER_DEPTH(4)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .R0_C_Valid(R0_C_Valid), .R0_C_Channel(R0_C_Channel), .R0_C_SOP(R0_C_SOP), .R0_C_EOP(R0_C_EOP), .R0_C_Ready(R0_C_Ready),
        .R1_C_Valid(R1_C_Valid), .R1_C_Channel(R1_C_Channel), .R1_C_SOP(R1_C_SOP), .R1_C_EOP(R1_C_EOP), .R1_C_Ready(R1_C_Ready),
        .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel), .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
        .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data), .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP),
        .R0_R_Valid(R0_R_Valid), .R1_R_Valid(R1_R_Valid), .R_Channel(R_Channel), .R_Data(R_Data), .R_SOP(R_SOP), .R_EOP(R_EOP),
        .Orphan(Orphan), .Orphan_clr(Orphan_clr)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        {R0_C_Valid, R0_C_SOP, R0_C_EOP, R0_C_Channel} = '0;
        {R1_C_Valid, R1_C_SOP, R1_C_EOP, R1_C_Channel} = '0;
        {ADC_C_Ready, ADC_R_Valid, ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data, Orphan_clr} = '0;
        step();
        step();
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if ({R0_C_Ready, R1_C_Ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b exp 00", {R0_C_Ready, R1_C_Ready}); end
        tests++; if (ADC_C_Valid !== 1'b0) begin fails++; $display("FAIL reset_adc_valid got %b exp 0", ADC_C_Valid); end
        tests++; if ({ADC_C_Channel, ADC_C_SOP, ADC_C_EOP} !== 7'd0) begin fails++; $display("FAIL reset_adc_cmd got %h exp 0", {ADC_C_Channel, ADC_C_SOP, ADC_C_EOP}); end
        tests++; if ({R0_R_Valid, R1_R_Valid, Orphan} !== 3'b000) begin fails++; $display("FAIL reset_resp got %b exp 000", {R0_R_Valid, R1_R_Valid, Orphan}); end
    endtask

    task automatic test_single();
        logic [4:0]  ch [3];
        logic [11:0] dat [3];
        ch = '{5'd1, 5'd2, 5'd17};
        dat = '{12'h111, 12'h222, 12'h333};
        do_reset();
        ADC_C_Ready = 1'b1;
        R0_C_Valid = 1'b1; R0_C_SOP = 1'b1; R0_C_Channel = ch[0];
        #1;
        tests++; if ({ADC_C_Valid, R0_C_Ready} !== 2'b00) begin fails++; $display("FAIL single_arb_cycle got %b exp 00", {ADC_C_Valid, R0_C_Ready}); end
        step();
        for (int i = 0; i < 3; i++) begin
            R0_C_SOP = (i == 0); R0_C_EOP = (i == 2); R0_C_Channel = ch[i];
            #1;
            tests++; if ({ADC_C_Valid, R0_C_Ready, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP} !== {2'b11, ch[i], i == 0, i == 2}) begin fails++; $display("FAIL single_beat%0d got %h exp %h", i, {ADC_C_Valid, R0_C_Ready, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP}, {2'b11, ch[i], i == 0, i == 2}); end
            step();
        end
        R0_C_Valid = 1'b0; R0_C_EOP = 1'b0;
        #1;
        tests++; if (ADC_C_Valid !== 1'b0) begin fails++; $display("FAIL single_after_eop got %b exp 0", ADC_C_Valid); end
        for (int i = 0; i < 3; i++) begin
            ADC_R_Valid = 1'b1; ADC_R_Channel = ch[i]; ADC_R_Data = dat[i];
            #1;
            tests++; if ({R0_R_Valid, R1_R_Valid, R_Channel, R_Data} !== {2'b10, ch[i], dat[i]}) begin fails++; $display("FAIL single_resp%0d got %h exp %h", i, {R0_R_Valid, R1_R_Valid, R_Channel, R_Data}, {2'b10, ch[i], dat[i]}); end
            step();
        end
        ADC_R_Valid = 1'b0;
        #1;
        tests++; if (Orphan !== 1'b0) begin fails++; $display("FAIL single_no_orphan got %b exp 0", Orphan); end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_ch;
        logic [1:0] exp_rv;
        do_reset();
        ADC_C_Ready = 1'b1;
        R0_C_Valid = 1'b1; R0_C_SOP = 1'b1; R0_C_EOP = 1'b1; R0_C_Channel = 5'd3;
        R1_C_Valid = 1'b1; R1_C_SOP = 1'b1; R1_C_EOP = 1'b1; R1_C_Channel = 5'd4;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef MFP_ADC_ARB_FIXED_PRIO_EN
            exp_ch = 5'd3;
`else
            exp_ch = (i % 2 == 0) ? 5'd3 : 5'd4;
`endif
            #1;
            tests++; if ({ADC_C_Valid, ADC_C_Channel} !== {1'b1, exp_ch}) begin fails++; $display("FAIL rr_grant%0d got %h exp %h", i, {ADC_C_Valid, ADC_C_Channel}, {1'b1, exp_ch}); end
            step();
        end
        R0_C_Valid = 1'b0; R1_C_Valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef MFP_ADC_ARB_FIXED_PRIO_EN
            exp_rv = 2'b01;
`else
            exp_rv = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            ADC_R_Valid = 1'b1;
            #1;
            tests++; if ({R1_R_Valid, R0_R_Valid} !== exp_rv) begin fails++; $display("FAIL rr_route%0d got %b exp %b", i, {R1_R_Valid, R0_R_Valid}, exp_rv); end
            step();
        end
        ADC_R_Valid = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        ADC_C_Ready = 1'b1;
        R0_C_Valid = 1'b1; R0_C_SOP = 1'b1; R0_C_Channel = 5'd5;
        step();
        step();
        R0_C_Valid = 1'b0; R0_C_SOP = 1'b0;
        R1_C_Valid = 1'b1; R1_C_SOP = 1'b1; R1_C_EOP = 1'b1; R1_C_Channel = 5'd6;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++; if ({R1_C_Ready, ADC_C_Valid} !== 2'b00) begin fails++; $display("FAIL lock_hold%0d got %b exp 00", i, {R1_C_Ready, ADC_C_Valid}); end
            step();
        end
        R0_C_Valid = 1'b1; R0_C_EOP = 1'b1; R0_C_Channel = 5'd7;
        #1;
        tests++; if ({ADC_C_Valid, ADC_C_Channel, ADC_C_EOP, R1_C_Ready} !== {1'b1, 5'd7, 1'b1, 1'b0}) begin fails++; $display("FAIL lock_eop got %h exp %h", {ADC_C_Valid, ADC_C_Channel, ADC_C_EOP, R1_C_Ready}, {1'b1, 5'd7, 1'b1, 1'b0}); end
        step();
        R0_C_Valid = 1'b0; R0_C_EOP = 1'b0;
        #1;
        tests++; if (ADC_C_Valid !== 1'b0) begin fails++; $display("FAIL lock_bubble got %b exp 0", ADC_C_Valid); end
        step();
        #1;
        tests++; if ({ADC_C_Valid, ADC_C_Channel, R1_C_Ready} !== {1'b1, 5'd6, 1'b1}) begin fails++; $display("FAIL lock_r1_grant got %h exp %h", {ADC_C_Valid, ADC_C_Channel, R1_C_Ready}, {1'b1, 5'd6, 1'b1}); end
        step();
        R1_C_Valid = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        ADC_C_Ready = 1'b1;
        R0_C_Valid = 1'b1; R0_C_SOP = 1'b1; R0_C_Channel = 5'd8;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (R0_C_Ready !== 1'b1) begin fails++; $display("FAIL full_accept%0d got %b exp 1", i, R0_C_Ready); end
            step();
            R0_C_SOP = 1'b0;
        end
        #1;
        tests++; if ({R0_C_Ready, ADC_C_Valid} !== 2'b00) begin fails++; $display("FAIL full_stall got %b exp 00", {R0_C_Ready, ADC_C_Valid}); end
        ADC_R_Valid = 1'b1;
        #1;
        tests++; if ({R0_R_Valid, R0_C_Ready} !== 2'b10) begin fails++; $display("FAIL full_pop_blocked got %b exp 10", {R0_R_Valid, R0_C_Ready}); end
        step();
        ADC_R_Valid = 1'b0;
        #1;
        tests++; if ({R0_C_Ready, ADC_C_Valid} !== 2'b11) begin fails++; $display("FAIL full_resume got %b exp 11", {R0_C_Ready, ADC_C_Valid}); end
        step();
        #1;
        tests++; if (R0_C_Ready !== 1'b0) begin fails++; $display("FAIL full_refill got %b exp 0", R0_C_Ready); end
        R0_C_Valid = 1'b0;
    endtask

    task automatic test_orphan();
        do_reset();
        ADC_R_Valid = 1'b1;
        #1;
        tests++; if ({R0_R_Valid, R1_R_Valid} !== 2'b00) begin fails++; $display("FAIL orphan_no_route got %b exp 00", {R0_R_Valid, R1_R_Valid}); end
        step();
        ADC_R_Valid = 1'b0;
        #1;
        tests++; if (Orphan !== 1'b1) begin fails++; $display("FAIL orphan_set got %b exp 1", Orphan); end
        step();
        #1;
        tests++; if (Orphan !== 1'b1) begin fails++; $display("FAIL orphan_sticky got %b exp 1", Orphan); end
        Orphan_clr = 1'b1;
        step();
        Orphan_clr = 1'b0;
        #1;
        tests++; if (Orphan !== 1'b0) begin fails++; $display("FAIL orphan_clear got %b exp 0", Orphan); end
        ADC_R_Valid = 1'b1; Orphan_clr = 1'b1;
        step();
        ADC_R_Valid = 1'b0; Orphan_clr = 1'b0;
        #1;
        tests++; if (Orphan !== 1'b1) begin fails++; $display("FAIL orphan_set_wins got %b exp 1", Orphan); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ADC_C_Ready = 1'b1;
        R0_C_Valid = 1'b1; R0_C_SOP = 1'b1; R0_C_Channel = 5'd9;
        step();
        step();
        R0_C_SOP = 1'b0; R0_C_Channel = 5'd10;
        RESETn = 1'b0; R0_C_Valid = 1'b0;
        step();
        RESETn = 1'b1;
        #1;
        tests++; if ({ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP, R0_C_Ready, R1_C_Ready, Orphan} !== 10'd0) begin fails++; $display("FAIL rstmid_outputs got %h exp 0", {ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP, R0_C_Ready, R1_C_Ready, Orphan}); end
        R0_C_Valid = 1'b1;
        #1;
        tests++; if ({R0_C_Ready, ADC_C_Valid} !== 2'b10) begin fails++; $display("FAIL rstmid_idle_discard got %b exp 10", {R0_C_Ready, ADC_C_Valid}); end
        step();
        R0_C_Valid = 1'b0;
        ADC_R_Valid = 1'b1;
        #1;
        tests++; if ({R0_R_Valid, R1_R_Valid} !== 2'b00) begin fails++; $display("FAIL rstmid_flushed got %b exp 00", {R0_R_Valid, R1_R_Valid}); end
        step();
        ADC_R_Valid = 1'b0;
        #1;
        tests++; if (Orphan !== 1'b1) begin fails++; $display("FAIL rstmid_stale_orphan got %b exp 1", Orphan); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_orphan();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mfp_adc_max10_arbiter.md
# mfp_adc_max10_arbiter

Packet-level arbiter that shares one Altera MAX10 ADC sequencer port between two requesters, e.g. the CPU-controlled ADC core and a DMA or auto-sampling core. Sits between the requesters' Avalon-ST command/response streams and the ADC IP. It grants whole command packets (SOP..EOP) atomically. An in-order owner FIFO steers each response beat back to the requester that issued the matching command.

## Interface
- OWNER_DEPTH, 8: owner FIFO entries (power of 2, ≥2); bounds commands in flight.
- CLK  in  1  clock.
- RESETn  in  1  reset; one clock; reset is synchronous and active-low.
- Rn_C_Valid  in  1  command valid from requester n (n = 0, 1).
- Rn_C_Channel  in  5  command channel from requester n.
- Rn_C_SOP  in  1  command start of packet from requester n.
- Rn_C_EOP  in  1  command end of packet from requester n.
- Rn_C_Ready  out  1  command accepted from requester n.
- ADC_C_Valid, ADC_C_SOP, ADC_C_EOP  out  1 each  command to the ADC.
- ADC_C_Channel  out  5  command channel to the ADC.
- ADC_C_Ready  in  1  ADC accepts the command.
- ADC_R_Valid, ADC_R_SOP, ADC_R_EOP  in  1 each  response from the ADC.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  response data.
- Rn_R_Valid  out  1  response valid, routed to requester n.
- R_Channel, R_Data, R_SOP, R_EOP  out  5/12/1/1  response fields, broadcast to both requesters (direct copy of ADC_R_*).
- Orphan  out  1  sticky flag: a response arrived with the owner FIFO empty.
- Orphan_clr  in  1  clears Orphan.

## Operation
- FSM states: S_IDLE, S_OWN0, S_OWN1. Reset state is S_IDLE.
- Arbitration happens in S_IDLE only. A candidate is a requester with Rn_C_Valid & Rn_C_SOP.
  - One candidate: that requester is granted.
  - Two candidates: round-robin. The requester not granted last time wins. The last-grant register resets to 1, so R0 wins the first tie.
  - Transition to S_OWNn on the next clock.
- In S_IDLE, a Valid beat without SOP is accepted (Rn_C_Ready = 1) and discarded, never forwarded. This prevents deadlock on malformed streams.
- In S_OWNn:
  - ADC_C_* = Rn_C_*. The other requester's Ready is 0.
  - Rn_C_Ready = ADC_C_Ready & ~fifo_full.
  - ADC_C_Valid = Rn_C_Valid & ~fifo_full.
- A beat transfers when ADC_C_Valid & ADC_C_Ready. Each transfer pushes owner id n into the FIFO.
- A transfer with EOP returns the FSM to S_IDLE and updates last-grant.
- Owner stays locked mid-packet even if Rn_C_Valid drops.
- Response routing:
  - On ADC_R_Valid with FIFO non-empty: pulse Rk_R_Valid, where k is the FIFO head, and pop.
  - On ADC_R_Valid with FIFO empty: no Rn_R_Valid; set Orphan.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Orphan: set has priority over Orphan_clr in the same cycle.

## Timing
- Arbitration latency: 1 clock from SOP candidate in S_IDLE to first forwarded beat. There is a 1-clock idle bubble between packets.
- Command path is combinational pass-through in S_OWNn. There is no registering.
- Response path is combinational, zero latency: Rk_R_Valid is in the same cycle as ADC_R_Valid.
- fifo_full is registered occupancy == OWNER_DEPTH. A push is blocked when full even if a pop occurs that cycle; it is accepted the next clock.
- Reset values:
  - All Ready and Valid outputs 0.
  - ADC_C_Channel, ADC_C_SOP, ADC_C_EOP 0 (command outputs are driven 0 in S_IDLE).
  - Orphan 0; FIFO empty.
- Reset mid-packet: FSM returns to S_IDLE and the FIFO is flushed. Responses still arriving afterwards set Orphan.

## Configuration
- MFP_ADC_ARB_FIXED_PRIO_EN
  - Defined: R0 always wins simultaneous SOP candidates. The last-grant register is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- Single requester R0 sends the 3-beat packet ch1/ch2/ch17, with ADC_C_Ready always 1:
  - forwarded on cycles 2..4 after SOP;
  - three responses yield R0_R_Valid ×3 and R1_R_Valid = 0.
- R0 and R1 both assert SOP in the same cycle, repeated over 4 packets:
  - grants alternate R0, R1, R0, R1;
  - with MFP_ADC_ARB_FIXED_PRIO_EN, all go to R0 until R0 idles.
- R0 drops Valid mid-packet for 5 cycles while R1 requests:
  - R1_C_Ready stays 0;
  - after R0's EOP, R1 is granted.
- OWNER_DEPTH = 4 with no responses:
  - the 5th command beat stalls (R0_C_Ready = 0);
  - one response pops the FIFO and the beat is accepted the following clock.
- A response arrives with an empty FIFO:
  - Orphan = 1 and no Rn_R_Valid;
  - Orphan_clr for one cycle clears it;
  - simultaneous orphan and clear leaves Orphan = 1.
- RESETn low for one clock mid-packet:
  - outputs are 0 next clock and the FSM is in S_IDLE;
  - a stale response sets Orphan.
